sd_read_arbiter: RTL and testbench
==================================

# sd_read_arbiter

Two-client scheduler that shares one `sd_reader` instance. Each client requests a run of consecutive sectors. The arbiter grants round-robin and sequences one `rstart`/`rdone` transaction per sector. It steers the sector byte stream to the granted client and reports completion or a watchdog error per request.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 24'd10_000_000: per-sector watchdog limit, in clk cycles.

Ports:
- `clk`: in, 1. System clock, same clock as `sd_reader`.
- `rstn`: in, 1. Reset, asynchronous, active-low.
- `req`: in, 2. `req[i]` is client i's request. It is held until `ack[i]`.
- `sector0`, `sector1`: in, 32 each. First sector number per client; the `sd_reader` does the byte-address conversion.
- `count0`, `count1`: in, 16 each. Number of sectors per client.
- `ack`: out, 2. One-cycle pulse when the request is granted and its fields are latched.
- `done`: out, 2. One-cycle pulse after the last sector completes.
- `err`: out, 2. One-cycle pulse when the watchdog expires. The request is abandoned.
- `busy`: out, 1. High in any state except IDLE.
- `data_valid`: out, 2. `data_valid[i]` marks a byte for client i. Never both bits high.
- `data_addr`: out, 9. Byte offset within the sector, 0..511.
- `data_byte`: out, 8. Sector byte.
- `data_idx`: out, 16. Sector index within the request, 0..count-1.
- `sd_rstart`: out, 1. Connects to `sd_reader.rstart`.
- `sd_rsector`: out, 32. Connects to `sd_reader.rsector`.
- `sd_rbusy`: in, 1. Connects to `sd_reader.rbusy`. Low means the card is initialized and idle.
- `sd_rdone`: in, 1. Connects to `sd_reader.rdone`.
- `sd_outen`, `sd_outaddr`, `sd_outbyte`: in, 1/9/8. Connect to the `sd_reader` output stream.

## Operation
Reset values:
- All outputs are 0.
- State is IDLE.
- `last_grant` is 1, so client 0 wins the first tie.
- `remaining`, current sector, `idx` and watchdog counter are 0.

States:
- **IDLE**
  - Arbitrate only when `req != 0` and `sd_rbusy == 0`. While the card is still initializing, requests stay pending.
  - Winner: the only requester, or on a tie the client other than `last_grant`.
  - On grant: pulse `ack[g]`, set `last_grant <= g`, latch sector and count, set `idx <= 0`.
  - If the count is 0: pulse `done[g]` together with `ack[g]` and stay in IDLE.
  - Otherwise go to ISSUE.
- **ISSUE**
  - Drive `sd_rstart = 1` for exactly one cycle with `sd_rsector` = current sector.
  - Clear the watchdog and go to WAIT_ACC.
- **WAIT_ACC**
  - Wait for `sd_rbusy == 1`, then go to WAIT_DONE.
- **WAIT_DONE**
  - Forward the byte stream to the granted client.
  - On `sd_rdone`: decrement `remaining`, increment the sector (32-bit wrap, 0xFFFFFFFF -> 0) and increment `idx`.
  - If `remaining` was 1: pulse `done[g]` and go to IDLE.
  - Otherwise go to GAP.
- **GAP**
  - Wait for `sd_rbusy == 0`, then go to ISSUE.
  - The same client keeps the reader; there is no re-arbitration mid-request.

Watchdog:
- Counts every cycle in WAIT_ACC, WAIT_DONE and GAP.
- At `TIMEOUT_CYCLES`: pulse `err[g]` and go to IDLE. `done` is not pulsed.
- The next grant still waits for `sd_rbusy == 0`.

Data path:
- `data_valid[g] <= sd_outen`, only in WAIT_DONE.
- `data_addr`, `data_byte` and `data_idx` are registered alongside `data_valid`.
- `sd_outen` is ignored in every other state.

Other rules:
- `sd_rsector` holds its value between issues.
- `sd_rstart` is 0 in every state except ISSUE.
- Dropping `req[i]` before `ack[i]` withdraws the request. `req` is ignored while busy.
- Simultaneous `sd_rdone` and watchdog expiry: `sd_rdone` wins.

## Timing
- Grant: `ack` is asserted in the clock after IDLE sees a qualifying `req`. The next cycle is ISSUE, with `sd_rstart` high.
- Data path latency: 1 clk from `sd_outen` to `data_valid`.
- `done`/`err`: asserted in the cycle after the triggering event is sampled.
- Back-to-back: after `done`, the next grant can occur one cycle later at the earliest.
- Asynchronous reset mid-request clears all state immediately, with no `done`/`err` pulse.

## Test plan
- Client 0 requests sector 0x10 with count 1, with a reader model: `ack[0]` pulses once; `sd_rstart` pulses once with `sd_rsector` = 0x10; 512 `data_valid[0]` beats at addr 0..511 with `data_idx` 0; then `done[0]`.
- Both clients request in the same cycle, counts 1 and 1: client 0 is served first, then client 1; `data_valid[1]` never overlaps client 0's data.
- Client 1 requests sector 0xFFFFFFFF with count 3: the reader sees sectors 0xFFFFFFFF, 0x0, 0x1; `data_idx` runs 0, 1, 2; exactly one `done[1]`.
- Request held while `sd_rbusy` stays 1 for 1000 cycles, as during init: no `ack` until `sd_rbusy` falls.
- Model never asserts `sd_rdone`, with `TIMEOUT_CYCLES` = 200: `err[0]` pulses about 200 cycles after the issue; `done[0]` stays 0; the state returns to IDLE.
- Request with count 0: `ack` and `done` pulse in the same cycle; no `sd_rstart`.
- Reset asserted mid-sector: all outputs drop to 0; after release, the first grant behaves as from power-up.

Source files
------------

// File: rtl/sd_read_arbiter.sv
// Round-robin arbiter sharing one sd_reader between two clients; each grant
// reads a run of consecutive sectors and streams the bytes back to its owner.
module sd_read_arbiter #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [1:0]  req,
  input  logic [31:0] sector0,
  input  logic [31:0] sector1,
  input  logic [15:0] count0,
  input  logic [15:0] count1,
  output logic [1:0]  ack,
  output logic [1:0]  done,
  output logic [1:0]  err,
  output logic        busy,
  output logic [1:0]  data_valid,
  output logic [8:0]  data_addr,
  output logic [7:0]  data_byte,
  output logic [15:0] data_idx,
  output logic        sd_rstart,
  output logic [31:0] sd_rsector,
  input  logic        sd_rbusy,
  input  logic        sd_rdone,
  input  logic        sd_outen,
  input  logic [8:0]  sd_outaddr,
  input  logic [7:0]  sd_outbyte
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_ACC, S_WAIT_DONE, S_GAP
  } state_t;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        grant_q, grant_d;
  logic [31:0] sector_q, sector_d;
  logic [15:0] remaining_q, remaining_d;
  logic [15:0] idx_q, idx_d;
  logic [23:0] wdog_q, wdog_d;
  logic [1:0]  ack_q, ack_d;
  logic [1:0]  done_q, done_d;
  logic [1:0]  err_q, err_d;
  logic [1:0]  dvalid_q, dvalid_d;
  logic [8:0]  daddr_q, daddr_d;
  logic [7:0]  dbyte_q, dbyte_d;
  logic [15:0] didx_q, didx_d;
  logic        rstart_q, rstart_d;
  logic [31:0] rsector_q, rsector_d;

  logic [1:0]  eligible;
  logic        pick;
  logic [1:0]  pick_mask;
  logic [1:0]  grant_mask;
  logic [15:0] pick_count;
  logic        wdog_expired;

  // A client whose ack is on the wire this cycle has not yet had the chance
  // to drop req, so it must not be granted a second time.
  always_comb begin
    eligible   = req & ~ack_q;
    pick       = (eligible == 2'b11) ? ~last_grant_q : eligible[1];
    pick_mask  = pick ? 2'b10 : 2'b01;
    pick_count = pick ? count1 : count0;
    grant_mask = grant_q ? 2'b10 : 2'b01;
  end

  assign wdog_expired = ({1'b0, wdog_q} + 25'd1) >= {1'b0, TIMEOUT_CYCLES};

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    sector_d     = sector_q;
    remaining_d  = remaining_q;
    idx_d        = idx_q;
    wdog_d       = wdog_q;
    ack_d        = 2'b00;
    done_d       = 2'b00;
    err_d        = 2'b00;
    dvalid_d     = 2'b00;
    daddr_d      = daddr_q;
    dbyte_d      = dbyte_q;
    didx_d       = didx_q;
    rstart_d     = 1'b0;
    rsector_d    = rsector_q;

    case (state_q)
      S_IDLE: begin
        if (eligible != 2'b00 && !sd_rbusy) begin
          grant_d      = pick;
          last_grant_d = pick;
          ack_d        = pick_mask;
          idx_d        = 16'd0;
          sector_d     = pick ? sector1 : sector0;
          remaining_d  = pick_count;
          if (pick_count == 16'd0) begin
            done_d = pick_mask;
          end else begin
            state_d   = S_ISSUE;
            rstart_d  = 1'b1;
            rsector_d = pick ? sector1 : sector0;
          end
        end
      end
      S_ISSUE: begin
        wdog_d  = 24'd0;
        state_d = S_WAIT_ACC;
      end
      S_WAIT_ACC: begin
        wdog_d = wdog_q + 24'd1;
        if (sd_rbusy) begin
          state_d = S_WAIT_DONE;
        end else if (wdog_expired) begin
          err_d   = grant_mask;
          state_d = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        wdog_d = wdog_q + 24'd1;
        if (sd_outen) begin
          dvalid_d = grant_mask;
          daddr_d  = sd_outaddr;
          dbyte_d  = sd_outbyte;
          didx_d   = idx_q;
        end
        // A sector finishing on the expiry cycle still counts as done.
        if (sd_rdone) begin
          remaining_d = remaining_q - 16'd1;
          sector_d    = sector_q + 32'd1;
          idx_d       = idx_q + 16'd1;
          if (remaining_q == 16'd1) begin
            done_d  = grant_mask;
            state_d = S_IDLE;
          end else begin
            state_d = S_GAP;
          end
        end else if (wdog_expired) begin
          err_d   = grant_mask;
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        wdog_d = wdog_q + 24'd1;
        if (!sd_rbusy) begin
          state_d   = S_ISSUE;
          rstart_d  = 1'b1;
          rsector_d = sector_q;
        end else if (wdog_expired) begin
          err_d   = grant_mask;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      sector_q     <= 32'd0;
      remaining_q  <= 16'd0;
      idx_q        <= 16'd0;
      wdog_q       <= 24'd0;
      ack_q        <= 2'b00;
      done_q       <= 2'b00;
      err_q        <= 2'b00;
      dvalid_q     <= 2'b00;
      daddr_q      <= 9'd0;
      dbyte_q      <= 8'd0;
      didx_q       <= 16'd0;
      rstart_q     <= 1'b0;
      rsector_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      sector_q     <= sector_d;
      remaining_q  <= remaining_d;
      idx_q        <= idx_d;
      wdog_q       <= wdog_d;
      ack_q        <= ack_d;
      done_q       <= done_d;
      err_q        <= err_d;
      dvalid_q     <= dvalid_d;
      daddr_q      <= daddr_d;
      dbyte_q      <= dbyte_d;
      didx_q       <= didx_d;
      rstart_q     <= rstart_d;
      rsector_q    <= rsector_d;
    end
  end

  assign ack        = ack_q;
  assign done       = done_q;
  assign err        = err_q;
  assign busy       = (state_q != S_IDLE);
  assign data_valid = dvalid_q;
  assign data_addr  = daddr_q;
  assign data_byte  = dbyte_q;
  assign data_idx   = didx_q;
  assign sd_rstart  = rstart_q;
  assign sd_rsector = rsector_q;

endmodule

// File: tb/tb_sd_read_arbiter.sv
// Bench for sd_read_arbiter: a behavioural sd_reader plus a transaction
// scoreboard of expected acks, issued sectors, byte beats and completions.
module tb_sd_read_arbiter;

  localparam int TO = 600;
  localparam logic [63:0] NONE = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  req;
  logic [31:0] sector0, sector1;
  logic [15:0] count0, count1;
  logic [1:0]  ack, done, err, data_valid;
  logic        busy, sd_rstart;
  logic [8:0]  data_addr;
  logic [7:0]  data_byte;
  logic [15:0] data_idx;
  logic [31:0] sd_rsector;
  logic        sd_rbusy, rbusy_m, init_busy, hang;
  logic        sd_rdone, sd_outen;
  logic [8:0]  sd_outaddr;
  logic [7:0]  sd_outbyte;

  assign sd_rbusy = rbusy_m | init_busy;

  sd_read_arbiter #(.TIMEOUT_CYCLES(24'(TO))) dut (
    .clk(clk), .rstn(rstn), .req(req),
    .sector0(sector0), .sector1(sector1), .count0(count0), .count1(count1),
    .ack(ack), .done(done), .err(err), .busy(busy),
    .data_valid(data_valid), .data_addr(data_addr), .data_byte(data_byte),
    .data_idx(data_idx), .sd_rstart(sd_rstart), .sd_rsector(sd_rsector),
    .sd_rbusy(sd_rbusy), .sd_rdone(sd_rdone), .sd_outen(sd_outen),
    .sd_outaddr(sd_outaddr), .sd_outbyte(sd_outbyte)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0, cyc = 0;
  int n_rstart, n_beats[2], n_done[2], n_err[2], issue_cyc, err_lat, last_idx, last_addr;
  logic [63:0] exp_ack[$], exp_sec[$], exp_beat[$], exp_end[$];
  logic [31:0] seen_sec[$];
  int ack_order[$];

  function automatic logic [7:0] fbyte(input logic [31:0] s, input logic [8:0] a);
    return s[7:0] ^ s[15:8] ^ a[7:0] ^ {a[8], 7'd0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    nvec++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic int pending();
    return exp_ack.size() + exp_sec.size() + exp_beat.size() + exp_end.size();
  endfunction

  task automatic flush();
    exp_ack.delete(); exp_sec.delete(); exp_beat.delete(); exp_end.delete();
  endtask

  task automatic clear_stats();
    n_rstart = 0; n_beats[0] = 0; n_beats[1] = 0; n_done[0] = 0; n_done[1] = 0;
    n_err[0] = 0; n_err[1] = 0; err_lat = 0; last_idx = -1; last_addr = -1;
    seen_sec.delete(); ack_order.delete();
  endtask

  // Whole request as the scoreboard sees it: one ack, then for each sector the
  // issued sector number and 512 beats carrying the sector's index, then done.
  task automatic expect_req(input int c, input logic [31:0] sec, input int cnt);
    logic [31:0] s;
    logic [8:0]  a9;
    s = sec;
    exp_ack.push_back(64'(c));
    for (int k = 0; k < cnt; k++) begin
      exp_sec.push_back(64'(s));
      for (int a = 0; a < 512; a++) begin
        a9 = a[8:0];
        exp_beat.push_back({30'd0, c[0], k[15:0], a9, fbyte(s, a9)});
      end
      s = s + 32'd1;
    end
    exp_end.push_back(64'(c * 2));
  endtask

  task automatic expect_timeout(input int c, input logic [31:0] sec);
    exp_ack.push_back(64'(c));
    exp_sec.push_back(64'(sec));
    exp_end.push_back(64'(c * 2 + 1));
  endtask

  // Behavioural sd_reader: busy one cycle after rstart, 512 bytes, rdone.
  initial begin
    logic [31:0] rsec;
    rbusy_m = 0; sd_rdone = 0; sd_outen = 0; sd_outaddr = 0; sd_outbyte = 0;
    forever begin
      @(posedge clk); #1;
      if (rstn && sd_rstart) begin
        rsec = sd_rsector;
        seen_sec.push_back(rsec);
        @(posedge clk); #1;
        rbusy_m = 1;
        if (hang) begin
          while (hang && rstn) begin @(posedge clk); #1; end
        end else begin
          for (int a = 0; a < 512 && rstn; a++) begin
            @(posedge clk); #1;
            if (rstn) begin
              sd_outen = 1; sd_outaddr = a[8:0]; sd_outbyte = fbyte(rsec, a[8:0]);
            end
          end
          @(posedge clk); #1;
          sd_outen = 0;
          if (rstn) begin
            sd_rdone = 1;
            @(posedge clk); #1;
            sd_rdone = 0;
          end
        end
        rbusy_m = 0; sd_outen = 0; sd_rdone = 0;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard: every visible event must be the next one the model expects.
  initial forever begin
    logic [63:0] e;
    @(negedge clk);
    if (rstn) begin
      if (sd_rstart) begin
        n_rstart++; issue_cyc = cyc;
        e = NONE; if (exp_sec.size() > 0) e = exp_sec.pop_front();
        chk("rsector", 64'(sd_rsector), e);
      end
      if (data_valid != 2'b00) begin
        chk("dv_exclusive", 64'(data_valid == 2'b11), 64'd0);
        n_beats[data_valid[1]]++; last_idx = int'(data_idx); last_addr = int'(data_addr);
        e = NONE; if (exp_beat.size() > 0) e = exp_beat.pop_front();
        chk("beat", {30'd0, data_valid[1], data_idx, data_addr, data_byte}, e);
      end
      for (int c = 0; c < 2; c++) begin
        if (ack[c]) begin
          ack_order.push_back(c);
          e = NONE; if (exp_ack.size() > 0) e = exp_ack.pop_front();
          chk("ack", 64'(c), e);
        end
        if (done[c]) begin
          n_done[c]++;
          e = NONE; if (exp_end.size() > 0) e = exp_end.pop_front();
          chk("end_done", 64'(c * 2), e);
        end
        if (err[c]) begin
          n_err[c]++; err_lat = cyc - issue_cyc;
          e = NONE; if (exp_end.size() > 0) e = exp_end.pop_front();
          chk("end_err", 64'(c * 2 + 1), e);
        end
      end
    end
  end

  task automatic drive_req(input int c, input logic [31:0] sec, input logic [15:0] cnt,
                           input int budget, output bit acked, output bit done_w_ack);
    if (c == 0) begin sector0 = sec; count0 = cnt; end
    else begin sector1 = sec; count1 = cnt; end
    req[c] = 1'b1;
    acked = 0; done_w_ack = 0;
    for (int i = 0; i < budget && !acked; i++) begin
      @(posedge clk); #1;
      if (ack[c]) begin acked = 1; done_w_ack = done[c]; req[c] = 1'b0; end
    end
    req[c] = 1'b0;
  endtask

  task automatic wait_drained(input string name, input int budget);
    int i;
    i = 0;
    while (pending() != 0 && i < budget) begin @(posedge clk); #1; i++; end
    chk({name, "_drained"}, 64'(pending()), 64'd0);
    flush();
    @(posedge clk); #1;
    chk({name, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic check_outs_zero(input string name);
    chk({name, "_ctl"}, {55'd0, ack, done, err, busy, data_valid}, 64'd0);
    chk({name, "_dp"}, {31'd0, data_addr, data_byte, data_idx}, 64'd0);
    chk({name, "_rd"}, {31'd0, sd_rstart, sd_rsector}, 64'd0);
  endtask

  // Both clients raise req in the same cycle from a fresh last_grant: 0 then 1.
  task automatic run_tie(input string name, input logic [31:0] s0, input logic [31:0] s1);
    logic [1:0] got;
    clear_stats();
    expect_req(0, s0, 1);
    expect_req(1, s1, 1);
    sector0 = s0; count0 = 16'd1; sector1 = s1; count1 = 16'd1;
    req = 2'b11; got = 2'b00;
    for (int i = 0; i < 2000 && got != 2'b11; i++) begin
      @(posedge clk); #1;
      for (int c = 0; c < 2; c++) if (ack[c]) begin got[c] = 1'b1; req[c] = 1'b0; end
    end
    req = 2'b00;
    chk({name, "_acks"}, 64'(got), 64'd3);
    wait_drained(name, 2000);
    chk({name, "_first"}, 64'(ack_order.size() > 0 ? ack_order[0] : -1), 64'd0);
    chk({name, "_second"}, 64'(ack_order.size() > 1 ? ack_order[1] : -1), 64'd1);
    chk({name, "_beats0"}, 64'(n_beats[0]), 64'd512);
    chk({name, "_beats1"}, 64'(n_beats[1]), 64'd512);
  endtask

  initial begin
    #900_000;
    $display("FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    bit acked, dwa;
    int i;
    rstn = 0; req = 0; sector0 = 0; sector1 = 0; count0 = 0; count1 = 0;
    init_busy = 0; hang = 0;
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    check_outs_zero("reset");
    rstn = 1;
    @(posedge clk); #1;

    run_tie("tie_powerup", 32'h20, 32'h30);

    // Card still initialising: request must stay pending.
    clear_stats();
    init_busy = 1;
    expect_req(0, 32'h10, 1);
    drive_req(0, 32'h10, 16'd1, 1000, acked, dwa);
    chk("init_no_ack", 64'(acked), 64'd0);
    init_busy = 0;
    drive_req(0, 32'h10, 16'd1, 10, acked, dwa);
    chk("init_ack_after", 64'(acked), 64'd1);
    wait_drained("single", 2000);
    chk("single_sec", 64'(seen_sec.size() > 0 ? seen_sec[0] : 32'hDEAD), 64'h10);
    chk("single_rstarts", 64'(n_rstart), 64'd1);
    chk("single_beats", 64'(n_beats[0]), 64'd512);
    chk("single_last_addr", 64'(last_addr), 64'd511);
    chk("single_done", 64'(n_done[0]), 64'd1);

    // Sector number wraps through 0xFFFFFFFF.
    clear_stats();
    expect_req(1, 32'hFFFF_FFFF, 3);
    drive_req(1, 32'hFFFF_FFFF, 16'd3, 20, acked, dwa);
    chk("wrap_ack", 64'(acked), 64'd1);
    wait_drained("wrap", 3000);
    chk("wrap_nsec", 64'(seen_sec.size()), 64'd3);
    chk("wrap_sec0", 64'(seen_sec.size() > 0 ? seen_sec[0] : 32'hDEAD), 64'hFFFF_FFFF);
    chk("wrap_sec1", 64'(seen_sec.size() > 1 ? seen_sec[1] : 32'hDEAD), 64'h0);
    chk("wrap_sec2", 64'(seen_sec.size() > 2 ? seen_sec[2] : 32'hDEAD), 64'h1);
    chk("wrap_beats", 64'(n_beats[1]), 64'd1536);
    chk("wrap_last_idx", 64'(last_idx), 64'd2);
    chk("wrap_done", 64'(n_done[1]), 64'd1);

    // Empty request: ack and done together, no reader traffic.
    clear_stats();
    expect_req(0, 32'h77, 0);
    drive_req(0, 32'h77, 16'd0, 20, acked, dwa);
    chk("zero_ack", 64'(acked), 64'd1);
    chk("zero_done_with_ack", 64'(dwa), 64'd1);
    wait_drained("zero", 20);
    chk("zero_rstarts", 64'(n_rstart), 64'd0);

    // Reader never finishes: watchdog abandons the request.
    clear_stats();
    hang = 1;
    expect_timeout(0, 32'h99);
    drive_req(0, 32'h99, 16'd1, 20, acked, dwa);
    chk("wdog_ack", 64'(acked), 64'd1);
    for (i = 0; i < 2 * TO && n_err[0] == 0; i++) @(posedge clk);
    #1;
    chk("wdog_err_count", 64'(n_err[0]), 64'd1);
    chk("wdog_latency", 64'(err_lat), 64'(TO + 1));
    chk("wdog_no_done", 64'(n_done[0]), 64'd0);
    wait_drained("wdog", 20);
    expect_req(1, 32'h5, 1);
    drive_req(1, 32'h5, 16'd1, 20, acked, dwa);
    chk("wdog_next_waits", 64'(acked), 64'd0);
    hang = 0;
    drive_req(1, 32'h5, 16'd1, 20, acked, dwa);
    chk("wdog_next_ack", 64'(acked), 64'd1);
    wait_drained("after_wdog", 2000);

    // Reset in the middle of a sector, then power-up arbitration again.
    clear_stats();
    expect_req(0, 32'h40, 2);
    drive_req(0, 32'h40, 16'd2, 20, acked, dwa);
    chk("midrst_ack", 64'(acked), 64'd1);
    for (i = 0; i < 1000 && n_beats[0] < 100; i++) begin @(posedge clk); #1; end
    chk("midrst_streaming", 64'(n_beats[0] >= 100), 64'd1);
    #2;
    rstn = 0;
    #1;
    check_outs_zero("midrst");
    flush();
    repeat (3) @(posedge clk);
    #1;
    rstn = 1;
    @(posedge clk); #1;
    run_tie("tie_after_reset", 32'h50, 32'h60);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
